// File: rtl/regfile_pkg.sv
// Shared defaults and the address-width derivation for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_RD   = 2;

    // ceil(log2(n)), never below one bit so a two-entry file still has an address line.
    function automatic int calc_aw(input int n);
        int aw;
        aw = 1;
        while ((1 << aw) < n) aw++;
        return aw;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracking: one bit per register, flush > set > clear priority,
// and a registered population count of the pending bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int AW       = calc_aw(DEF_NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [AW:0]         pend_cnt
);

    logic [NUM_REGS-1:0] r_busy;
    logic [AW:0]         r_cnt;
    logic [NUM_REGS-1:0] w_pend_next;
    logic [AW:0]         w_cnt_next;
    logic                w_clr_ok;
    logic                w_set_ok;

    // NOTE: every variable written here gets a default first, otherwise a path
    // that skips an assignment infers a latch.
    always_comb begin
        w_clr_ok    = wr_en && (wr_addr != '0) && (int'(wr_addr) < NUM_REGS);
        w_set_ok    = iss_en && (iss_addr != '0) && (int'(iss_addr) < NUM_REGS);
        w_pend_next = r_busy;
        if (flush) begin
            w_pend_next = '0;
        end else begin
            // The set is applied after the clear so a new producer supersedes the old one.
            if (w_clr_ok) w_pend_next[wr_addr]  = 1'b0;
            if (w_set_ok) w_pend_next[iss_addr] = 1'b1;
        end
        w_cnt_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_pend_next[i]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_pend_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign busy_vec = r_busy;
    assign pend_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with pending-producer scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = DEF_NUM_RD,
    localparam int AW       = calc_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    input  logic                     flush,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic [AW:0]              pend_cnt
);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy_vec;
    logic [AW-1:0]       w_ra;
    logic                w_wr_ok;

    assign w_wr_ok = wr_en && (wr_addr != '0) && (int'(wr_addr) < NUM_REGS);

    // NOTE: the array is reset entry by entry because reads must show zeros during
    // reset; this rules out mapping it onto a RAM macro without a reset port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_ra    = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_ra = rd_addr[p*AW +: AW];
            if (int'(w_ra) < NUM_REGS) begin
                rd_data[p*DATA_W +: DATA_W] = r_regs[w_ra];
                rd_busy[p]                  = w_busy_vec[w_ra];
            end
`ifdef REGFILE_BYPASS_EN
            // A same-cycle issue to the address means a newer producer is already in flight.
            if (rst_n && w_wr_ok && (w_ra == wr_addr) && !(iss_en && (iss_addr == w_ra))) begin
                rd_data[p*DATA_W +: DATA_W] = wr_data;
                rd_busy[p]                  = 1'b0;
            end
`endif
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (w_busy_vec),
        .pend_cnt (pend_cnt)
    );

    assign busy_vec = w_busy_vec;

endmodule

// File: tb/tb_regfile_sb.sv
// Table-driven bench for regfile_sb: each step checks the pre-edge view (reads,
// busy flags, pending count) against expectations queued when the step is driven.
module tb_regfile_sb;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int NUM_RD   = 2;
    localparam int AW       = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic                     flush;
    logic [NUM_REGS-1:0]      busy_vec;
    logic [AW:0]              pend_cnt;

    regfile_sb #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_vec (busy_vec),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  erb;
        logic [31:0] ebv;
        logic [5:0]  ecnt;
        int          step;
    } exp_t;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ie;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        exp_t        exp;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input int step,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d actual=%0h expected=%0h", name, step, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic ie, input logic [4:0] ia,
                                input logic fl, input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic [1:0] erb, input logic [31:0] ebv,
                                input logic [5:0] ecnt);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.ie = ie; v.ia = ia; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1;
        v.exp.e0 = e0; v.exp.e1 = e1; v.exp.erb = erb; v.exp.ebv = ebv; v.exp.ecnt = ecnt;
        v.exp.step = 0;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int step);
        exp_t e;
        @(negedge clk);
        rst_n    = v.rst;
        wr_en    = v.we;
        wr_addr  = v.wa;
        wr_data  = v.wd;
        iss_en   = v.ie;
        iss_addr = v.ia;
        flush    = v.fl;
        rd_addr  = {v.ra1, v.ra0};
        e        = v.exp;
        e.step   = step;
        exp_q.push_back(e);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", step, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("rd_data0", e.step, {32'd0, rd_data[31:0]},  {32'd0, e.e0});
            check("rd_data1", e.step, {32'd0, rd_data[63:32]}, {32'd0, e.e1});
            check("rd_busy",  e.step, {62'd0, rd_busy},        {62'd0, e.erb});
            check("busy_vec", e.step, {32'd0, busy_vec},       {32'd0, e.ebv});
            check("pend_cnt", e.step, {58'd0, pend_cnt},       {58'd0, e.ecnt});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset sweep of every address on both ports.
        for (int a = 0; a < NUM_REGS; a++) begin
            @(negedge clk);
            rd_addr = {a[4:0], a[4:0]};
            #1;
            check("sweep_rd0", a, {32'd0, rd_data[31:0]},  64'd0);
            check("sweep_rd1", a, {32'd0, rd_data[63:32]}, 64'd0);
            check("sweep_rb",  a, {62'd0, rd_busy},        64'd0);
        end
        check("sweep_busy_vec", 0, {32'd0, busy_vec}, 64'd0);
        check("sweep_pend_cnt", 0, {58'd0, pend_cnt}, 64'd0);

        //             rst we wa  wd            ie ia  fl ra0 ra1  e0                            e1                           erb                 ebv                      cnt
        vecs.push_back(mk(0, 1, 5,  32'hFFFF_FFFF, 1, 3,  0, 5,  3,  0,                            0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 5,  3,  0,                            0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 1, 5,  32'hDEAD_BEEF, 0, 0,  0, 5,  5,  BYP ? 32'hDEAD_BEEF : 32'd0, BYP ? 32'hDEAD_BEEF : 32'd0, 2'b00,              0,                       0));
        vecs.push_back(mk(1, 1, 0,  32'h0000_1234, 0, 0,  0, 5,  5,  32'hDEAD_BEEF,                32'hDEAD_BEEF,               2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 0,  0,  0,                            0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             1, 7,  0, 7,  5,  0,                            32'hDEAD_BEEF,               2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 7,  0,  0,                            0,                           2'b01,              32'h80,                  1));
        vecs.push_back(mk(1, 1, 7,  32'hA5A5_A5A5, 0, 0,  0, 7,  7,  BYP ? 32'hA5A5_A5A5 : 32'd0, BYP ? 32'hA5A5_A5A5 : 32'd0, BYP ? 2'b00 : 2'b11, 32'h80,                  1));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 7,  7,  32'hA5A5_A5A5,                32'hA5A5_A5A5,               2'b00,              0,                       0));
        vecs.push_back(mk(1, 1, 3,  32'h0000_3333, 1, 3,  0, 3,  2,  0,                            0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 3,  3,  32'h3333,                     32'h3333,                    2'b11,              32'h8,                   1));
        vecs.push_back(mk(1, 0, 0,  0,             1, 9,  0, 9,  3,  0,                            32'h3333,                    2'b10,              32'h8,                   1));
        vecs.push_back(mk(1, 1, 9,  32'h0000_0055, 0, 0,  0, 9,  3,  BYP ? 32'h55 : 32'd0,         32'h3333,                    BYP ? 2'b10 : 2'b11, 32'h208,                2));
        vecs.push_back(mk(1, 1, 3,  32'h0000_4444, 1, 1,  0, 9,  3,  32'h55,                       BYP ? 32'h4444 : 32'h3333,   BYP ? 2'b00 : 2'b10, 32'h8,                  1));
        vecs.push_back(mk(1, 0, 0,  0,             1, 2,  0, 3,  1,  32'h4444,                     0,                           2'b10,              32'h2,                   1));
        vecs.push_back(mk(1, 0, 0,  0,             1, 4,  0, 1,  2,  0,                            0,                           2'b11,              32'h6,                   2));
        vecs.push_back(mk(1, 1, 10, 32'h0000_00AB, 1, 6,  1, 4,  6,  0,                            0,                           2'b01,              32'h16,                  3));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 6,  10, 0,                            32'hAB,                      2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             1, 12, 0, 10, 12, 32'hAB,                       0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             1, 13, 0, 12, 13, 0,                            0,                           2'b01,              32'h1000,                1));
        vecs.push_back(mk(0, 1, 5,  32'h0000_0777, 1, 14, 0, 5,  13, 32'hDEAD_BEEF,                0,                           2'b10,              32'h3000,                2));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 5,  7,  0,                            0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 1, 5,  32'h0000_0001, 1, 8,  0, 5,  8,  BYP ? 32'h1 : 32'd0,          0,                           2'b00,              0,                       0));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 5,  8,  32'h1,                        0,                           2'b10,              32'h100,                 1));
        vecs.push_back(mk(1, 1, 31, 32'hCAFE_F00D, 1, 30, 0, 31, 30, BYP ? 32'hCAFE_F00D : 32'd0,  0,                           2'b00,              32'h100,                 1));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 31, 30, 32'hCAFE_F00D,                0,                           2'b10,              32'h4000_0100,           2));
        vecs.push_back(mk(1, 0, 0,  0,             1, 0,  0, 0,  8,  0,                            0,                           2'b10,              32'h4000_0100,           2));
        vecs.push_back(mk(1, 0, 0,  0,             0, 0,  0, 0,  8,  0,                            0,                           2'b10,              32'h4000_0100,           2));

        for (int s = 0; s < vecs.size(); s++) begin
            apply(vecs[s], s);
        end

        check("queue_drained", vecs.size(), 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL: DATA_W, default 32, register and bus width in bits.
REQ-002 SHALL: NUM_REGS, default 32, number of architectural registers, range 2..64; AW = ceil(log2(NUM_REGS)).
REQ-003 SHALL: NUM_RD, default 2, number of asynchronous read ports, range 1..4.
REQ-004 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL: rst_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL: rd_addr  in  NUM_RD*AW  packed read addresses, port i at bits [i*AW +: AW].
REQ-007 SHALL: rd_data  out  NUM_RD*DATA_W  packed read data, port i at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL: rd_busy  out  NUM_RD  port i reads a register whose producer is still outstanding.
REQ-009 SHALL: wr_en, wr_addr, wr_data  in  1, AW, DATA_W  write-back port.
REQ-010 SHALL: iss_en, iss_addr  in  1, AW  issue port; marks the destination register as pending.
REQ-011 SHALL: flush  in  1  clears all pending marks.
REQ-012 SHALL: busy_vec  out  NUM_REGS  registered pending bit per register.
REQ-013 SHALL: pend_cnt  out  AW+1  registered population count of busy_vec.

Function
REQ-014 SHALL: the read path is combinational, with zero-cycle latency from rd_addr to rd_data and rd_busy.
REQ-015 SHALL: register 0 always reads 0, is never written and is never marked pending.
REQ-016 SHALL: an address at or above NUM_REGS reads 0 with rd_busy=0, and any write or issue to it is ignored.
REQ-017 SHALL: when wr_en=1, wr_addr!=0 and rst_n=1, regs[wr_addr] takes wr_data at the rising edge; otherwise the register array holds.
REQ-018 SHALL: every read port is independent; identical addresses on several ports return identical data.
REQ-019 SHALL: when iss_en=1, pending[iss_addr] is set at the next edge; when wr_en=1, pending[wr_addr] is cleared at the next edge.
REQ-020 SHALL: when iss_en and wr_en target the same address in one cycle, the set wins (a new producer supersedes the old one); the data write still occurs.
REQ-021 SHALL: flush=1 clears every pending bit at the next edge and overrides any iss_en in the same cycle; a wr_en data write in that cycle still occurs.
REQ-022 SHALL: pend_cnt equals popcount(busy_vec) every cycle and never exceeds NUM_REGS-1.
REQ-023 SHALL: rd_busy[i] = busy_vec[rd_addr[i]], qualified as required by REQ-027.

Reset
REQ-024 SHALL: while rst_n=0 at a rising edge, all registers are set to 0, busy_vec to 0 and pend_cnt to 0; wr_en, iss_en and flush are ignored in that cycle.
REQ-025 SHALL: during reset, rd_data shows all zeros and rd_busy shows 0 from the first edge after rst_n falls.
REQ-026 SHALL: the first write or issue takes effect at the first edge with rst_n=1.

Configuration
REQ-027 SHALL: with REGFILE_BYPASS_EN defined, a read whose address matches a same-cycle wr_en/wr_addr (nonzero and in range) returns wr_data and drives rd_busy[i]=0, unless iss_en targets that address in the same cycle.
REQ-028 SHALL: without REGFILE_BYPASS_EN, reads return the stored value only, and a write becomes visible (data and busy clear) one cycle after the write edge.

Structure
REQ-029 SHALL: the package regfile_pkg holds the default DATA_W, NUM_REGS and NUM_RD values and the AW derivation function.
REQ-030 SHALL: the pending bits, the flush/set/clear priority logic and pend_cnt live in the sub-module regfile_scoreboard; the data array and read muxes live in regfile_sb.

Verification
REQ-031 SHALL: reset then read all addresses -> all rd_data=0, busy_vec=0, pend_cnt=0.
REQ-032 SHALL: write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> 0xDEADBEEF on both; a write of 0x1234 to r0 then reading r0 -> 0.
REQ-033 SHALL: issue r7, then write r7 (0xA5A5A5A5) two cycles later -> busy_vec[7]=1 and pend_cnt=1 between the two, then 0/0; rd_busy tracks busy_vec[7].
REQ-034 SHALL: same-cycle iss_en and wr_en both to r3 -> busy_vec[3]=1 next cycle and the data is updated.
REQ-035 SHALL: same-cycle write r9=0x55 and read r9 -> 0x55 and rd_busy=0 with REGFILE_BYPASS_EN; the old value without it.
REQ-036 SHALL: issue r1, r2 and r4, then flush together with iss_en r6 -> pend_cnt=0 next cycle; rst_n=0 mid-sequence -> everything is zero at the next edge.
